// File: rtl/rgb_pkg.sv
// rtl/rgb_pkg.sv - shared constants, field offsets and FSM encoding for the RGB pixel path
package rgb_pkg;

  localparam int BITS_PER_PIX_DEF = 24;

  // GRB word layout, MSB of each colour field
  localparam int G_MSB = 23;
  localparam int R_MSB = 15;
  localparam int B_MSB = 7;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  // Serial line timing in ns, used by stimulus generators
  localparam int T0H_NS     = 400;
  localparam int T1H_NS     = 800;
  localparam int T1L_NS     = 450;
  localparam int T0L_NS     = 850;
  localparam int RGB_RST_NS = 50000;

endpackage

// File: rtl/rgb_pix_fifo2.sv
// rtl/rgb_pix_fifo2.sv - 2-entry valid/ready buffer with registered head-of-queue output
module rgb_pix_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] s_tdata,
  input  logic         s_tvalid,
  output logic         s_tready,
  output logic [W-1:0] m_tdata,
  output logic         m_tvalid,
  input  logic         m_tready
);

  logic [W-1:0] tail_data;
  logic         tail_valid;
  logic         pop;
  logic         push;

  // Pop is evaluated before push, so a full buffer still accepts when draining
  assign pop      = m_tvalid && m_tready;
  assign s_tready = !tail_valid || pop;
  assign push     = s_tvalid && s_tready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_tdata    <= '0;
      m_tvalid   <= 1'b0;
      tail_data  <= '0;
      tail_valid <= 1'b0;
    end else if (pop) begin
      if (tail_valid) begin
        m_tdata    <= tail_data;
        tail_valid <= push;
        if (push) tail_data <= s_tdata;
      end else begin
        m_tvalid <= push;
        if (push) m_tdata <= s_tdata;
      end
    end else if (push) begin
      if (!m_tvalid) begin
        m_tdata  <= s_tdata;
        m_tvalid <= 1'b1;
      end else begin
        tail_data  <= s_tdata;
        tail_valid <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/rgb_pix_assembler.sv
// rtl/rgb_pix_assembler.sv - assembles serial bits into indexed GRB words; RGB_FRAME_COUNT_EN adds frame_pix_cnt
module rgb_pix_assembler
  import rgb_pkg::*;
#(
  parameter int BITS_PER_PIX = BITS_PER_PIX_DEF,
  parameter int PIX_IDX_W    = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    strobe,
  input  logic                    sbit_value,
  input  logic                    stream_reset,
  output logic [BITS_PER_PIX-1:0] pix_grb,
  output logic [PIX_IDX_W-1:0]    pix_idx,
  output logic                    pix_valid,
  input  logic                    pix_ready,
  output logic                    frame_done,
  output logic                    frag_err,
  output logic                    overrun
`ifdef RGB_FRAME_COUNT_EN
  ,
  output logic [PIX_IDX_W:0]      frame_pix_cnt
`endif
);

  localparam int CNT_W  = $clog2(BITS_PER_PIX + 1);
  localparam int FIFO_W = BITS_PER_PIX + PIX_IDX_W;
  localparam logic [PIX_IDX_W-1:0] IDX_MAX = '1;

  state_t                  state, state_nxt;
  logic [BITS_PER_PIX-1:0] shreg, shreg_nxt, shifted;
  logic [CNT_W-1:0]        bit_cnt, bit_cnt_nxt;
  logic [PIX_IDX_W-1:0]    idx;
  logic                    word_done;
  logic                    done_seen;
  logic                    fifo_ready;
  logic                    drop;
  logic [FIFO_W-1:0]       head;

  assign shifted = {shreg[BITS_PER_PIX-2:0], sbit_value};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
    end else begin
      state   <= state_nxt;
      shreg   <= shreg_nxt;
      bit_cnt <= bit_cnt_nxt;
    end
  end

  // stream_reset overrides a coincident strobe; that bit is discarded
  always_comb begin
    state_nxt   = state;
    shreg_nxt   = shreg;
    bit_cnt_nxt = bit_cnt;
    word_done   = 1'b0;
    if (stream_reset) begin
      state_nxt   = S_IDLE;
      shreg_nxt   = '0;
      bit_cnt_nxt = '0;
    end else if (strobe) begin
      shreg_nxt = shifted;
      unique case (state)
        S_IDLE: begin
          bit_cnt_nxt = CNT_W'(1);
          state_nxt   = S_SHIFT;
        end
        S_SHIFT: begin
          if (bit_cnt == CNT_W'(BITS_PER_PIX - 1)) begin
            word_done   = 1'b1;
            bit_cnt_nxt = '0;
            state_nxt   = S_IDLE;
          end else begin
            bit_cnt_nxt = bit_cnt + CNT_W'(1);
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  assign drop = word_done && !fifo_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx        <= '0;
      done_seen  <= 1'b0;
      frame_done <= 1'b0;
      frag_err   <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_done <= stream_reset && done_seen;
      frag_err   <= stream_reset && (bit_cnt != '0);
      if (stream_reset) begin
        idx       <= '0;
        done_seen <= 1'b0;
        overrun   <= 1'b0;
      end else begin
        if (word_done) begin
          done_seen <= 1'b1;
          if (idx != IDX_MAX) idx <= idx + PIX_IDX_W'(1);
        end
        if (drop) overrun <= 1'b1;
      end
    end
  end

`ifdef RGB_FRAME_COUNT_EN
  logic [PIX_IDX_W:0] words_cnt;

  // Counts every completed word, dropped ones included
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      words_cnt     <= '0;
      frame_pix_cnt <= '0;
    end else if (stream_reset) begin
      words_cnt <= '0;
      if (words_cnt != '0) frame_pix_cnt <= words_cnt;
    end else if (word_done && words_cnt != '1) begin
      words_cnt <= words_cnt + (PIX_IDX_W + 1)'(1);
    end
  end
`endif

  rgb_pix_fifo2 #(
    .W(FIFO_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .s_tdata ({shifted, idx}),
    .s_tvalid(word_done),
    .s_tready(fifo_ready),
    .m_tdata (head),
    .m_tvalid(pix_valid),
    .m_tready(pix_ready)
  );

  assign pix_grb = head[FIFO_W-1:PIX_IDX_W];
  assign pix_idx = head[PIX_IDX_W-1:0];

endmodule
